// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: reset stretcher and run control (free-run, single-step, run-N)
// Optional watchdog is built when CPU_RUN_CTRL_WDOG_EN is defined.
module cpu_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 5,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             step,
    input  logic [CNT_W-1:0] run_len,
    input  logic             halt_req,
    output logic             core_rst,
    output logic             cpu_ce,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             halted,
    output logic             timed_out
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT,
        S_RUN,
        S_STEP,
        S_HALT
    } state_t;

    localparam int unsigned HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] BUD_ONE = CNT_W'(1);

    if (RST_CYCLES < 1 || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("cpu_run_ctrl: RST_CYCLES and WDOG_CYCLES must be >= 1");
    end

    state_t           state_q;
    logic [HW-1:0]    hold_q;
    logic             runn_q;
    logic [CNT_W-1:0] budget_q;
    logic             pend_q;
    logic             core_rst_q;
    logic             cpu_ce_q;
    logic [CNT_W-1:0] cnt_q;
    logic             halted_q;

    logic start_ok;
    logic wd_hit;
    logic bud_done;

    assign start_ok = start && (state_q == S_WAIT || state_q == S_HALT);
    assign bud_done = runn_q && (budget_q == BUD_ONE);

`ifdef CPU_RUN_CTRL_WDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wd_q;
    logic          to_q;

    assign wd_hit    = (state_q == S_RUN) && (wd_q == WD_LAST);
    assign timed_out = to_q;

    // Watchdog: counts enabled RUN cycles since the last start; flag is sticky
    always_ff @(posedge clkin) begin
        if (reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            if (start_ok) begin
                wd_q <= '0;
            end else if (state_q == S_RUN) begin
                wd_q <= wd_q + WW'(1);
            end
            if (wd_hit) begin
                to_q <= 1'b1;
            end
        end
    end
`else
    assign wd_hit    = 1'b0;
    assign timed_out = 1'b0;
`endif

    // Main sequencer; outputs are registered from the current state so
    // start and halt both take effect one edge after the state change
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q    <= S_HOLD;
            hold_q     <= '0;
            runn_q     <= 1'b0;
            budget_q   <= '0;
            pend_q     <= 1'b0;
            core_rst_q <= 1'b1;
            cpu_ce_q   <= 1'b0;
            cnt_q      <= '0;
            halted_q   <= 1'b0;
        end else begin
            cpu_ce_q <= (state_q == S_RUN) || (state_q == S_STEP && pend_q);
            halted_q <= (state_q == S_HALT);
            if (cpu_ce_q) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                S_HOLD: begin
                    hold_q <= hold_q + HW'(1);
                    if (hold_q == HOLD_LAST) begin
                        core_rst_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end
                end
                S_RUN: begin
                    if (runn_q) begin
                        budget_q <= budget_q - BUD_ONE;
                    end
                    if (halt_req || wd_hit || bud_done) begin
                        state_q <= S_HALT;
                    end
                end
                S_STEP: begin
                    if (halt_req) begin
                        pend_q  <= 1'b0;
                        state_q <= S_HALT;
                    end else if (pend_q) begin
                        pend_q <= 1'b0;
                    end else begin
                        pend_q <= step;
                    end
                end
                S_WAIT, S_HALT: begin
                    if (start) begin
                        pend_q <= 1'b0;
                        runn_q <= 1'b0;
                        unique case (mode)
                            2'b01: state_q <= S_STEP;
                            2'b10: begin
                                runn_q   <= 1'b1;
                                budget_q <= run_len;
                                if (run_len == '0) begin
                                    state_q <= S_HALT;
                                end else begin
                                    state_q <= S_RUN;
                                end
                            end
                            default: state_q <= S_RUN;
                        endcase
                    end
                end
                default: state_q <= S_HOLD;
            endcase
        end
    end

    assign core_rst  = core_rst_q;
    assign cpu_ce    = cpu_ce_q;
    assign cycle_cnt = cnt_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed checks of reset stretch, run-N, step,
// halt/resume, mid-run reset and the watchdog (or its absence).
module tb_cpu_run_ctrl;

    localparam int RST = 5;
    localparam int CW  = 16;
    localparam int WD  = 16;
`ifdef CPU_RUN_CTRL_WDOG_EN
    localparam int EXP20 = 16;
`else
    localparam int EXP20 = 20;
`endif

    logic          clkin = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic          start;
    logic          step;
    logic [CW-1:0] run_len;
    logic          halt_req;
    logic          core_rst;
    logic          cpu_ce;
    logic [CW-1:0] cycle_cnt;
    logic          halted;
    logic          timed_out;

    int n_tests = 0;
    int n_fail  = 0;
    int ce_seen = 0;
    logic rst_seen = 1'b0;

    cpu_run_ctrl #(
        .RST_CYCLES (RST),
        .CNT_W      (CW),
        .WDOG_CYCLES(WD)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .mode     (mode),
        .start    (start),
        .step     (step),
        .run_len  (run_len),
        .halt_req (halt_req),
        .core_rst (core_rst),
        .cpu_ce   (cpu_ce),
        .cycle_cnt(cycle_cnt),
        .halted   (halted),
        .timed_out(timed_out)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
        if (cpu_ce) ce_seen++;
        if (core_rst) rst_seen = 1'b1;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [CW-1:0] len);
        mode    = m;
        run_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic hold_seq(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (core_rst && n < 20);
        check({tag, "_len"}, n, RST);
        check({tag, "_ce"}, cpu_ce, 0);
        check({tag, "_cnt"}, cycle_cnt, 0);
        check({tag, "_halted"}, halted, 0);
    endtask

    initial begin
        int first_ce;
        int last_ce;
        int first_h;
        logic seen_low;
        logic [31:0] mask;

        reset = 1'b1; mode = 2'b00; start = 1'b0; step = 1'b0;
        run_len = '0; halt_req = 1'b0;
        repeat (5) tick();
        check("rst_core_rst", core_rst, 1);
        check("rst_ce", cpu_ce, 0);
        check("rst_cnt", cycle_cnt, 0);
        check("rst_halted", halted, 0);
        check("rst_timed_out", timed_out, 0);
        reset = 1'b0;
        hold_seq("hold1");

        // free-run, halt_req sampled on the 7th enabled edge
        do_start(2'b00, '0);
        check("fr_start_lat", cpu_ce, 0);
        ce_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            halt_req = (i == 7);
            tick();
            halt_req = 1'b0;
        end
        check("fr_ce_cycles", ce_seen, 7);
        check("fr_cnt", cycle_cnt, 7);
        check("fr_halted", halted, 1);

        // resume from HALT without core reset
        rst_seen = 1'b0;
        do_start(2'b00, '0);
        ce_seen = 0;
        tick();
        tick();
        check("resume_cnt", cycle_cnt, 8);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        tick();
        check("resume_ce", ce_seen, 3);
        check("resume_cnt_end", cycle_cnt, 10);
        check("resume_no_rst", rst_seen, 0);

        // run-N = 10, with an ignored start mid-run
        do_start(2'b10, 16'd10);
        ce_seen = 0; first_ce = 0; last_ce = 0; first_h = 0;
        seen_low = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 4) begin
                start = 1'b1;
                run_len = 16'd3;
            end
            tick();
            start = 1'b0;
            if (cpu_ce) begin
                if (first_ce == 0) first_ce = i;
                last_ce = i;
            end
            if (!halted) seen_low = 1'b1;
            if (halted && seen_low && first_h == 0) first_h = i;
        end
        check("runn_first_ce", first_ce, 1);
        check("runn_last_ce", last_ce, 10);
        check("runn_ce_cycles", ce_seen, 10);
        check("runn_halt_edge", first_h, 11);
        check("runn_cnt", cycle_cnt, 20);

        // run-N with zero budget goes straight to HALT
        do_start(2'b10, '0);
        ce_seen = 0;
        repeat (4) tick();
        check("runn0_ce", ce_seen, 0);
        check("runn0_halted", halted, 1);

        // single-step; the step at 11 lands while a grant is pending
        do_start(2'b01, '0);
        ce_seen = 0;
        mask = '0;
        for (int i = 1; i <= 16; i++) begin
            step = (i == 2 || i == 6 || i == 10 || i == 11);
            tick();
            step = 1'b0;
            if (cpu_ce) mask[i] = 1'b1;
        end
        check("step_mask", mask, 32'h0000_0888);
        check("step_ce", ce_seen, 3);
        check("step_cnt", cycle_cnt, 23);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        check("step_halted", halted, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        check("halt_step_ign", ce_seen, 3);

        // reset in the middle of a free run
        do_start(2'b00, '0);
        ce_seen = 0;
        repeat (20) tick();
        check("mid_ce", ce_seen, EXP20);
        reset = 1'b1;
        tick();
        check("mid_rst_core", core_rst, 1);
        check("mid_rst_ce", cpu_ce, 0);
        check("mid_rst_cnt", cycle_cnt, 0);
        check("mid_rst_halted", halted, 0);
        reset = 1'b0;
        hold_seq("hold2");

        // long free run: watchdog trips only when compiled in
        do_start(2'b00, '0);
        ce_seen = 0;
        repeat (24) tick();
`ifdef CPU_RUN_CTRL_WDOG_EN
        check("wd_ce", ce_seen, 16);
        check("wd_timed_out", timed_out, 1);
        check("wd_halted", halted, 1);
        check("wd_cnt", cycle_cnt, 16);
`else
        check("nowd_ce", ce_seen, 24);
        check("nowd_timed_out", timed_out, 0);
        check("nowd_running", cpu_ce, 1);
        check("nowd_cnt", cycle_cnt, 23);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
